ysyx_25070198_mem_arbiter: RTL and testbench
============================================

# ysyx_25070198_mem_arbiter

Two-requester arbiter that shares the single DPI memory port between instruction fetch (IFU) and load/store (LSU). It replaces the direct combinational `pmem_read` calls with a serialized valid/ready request path and a one-cycle response pulse, so the core becomes multi-cycle. It sits between the IFU/LSU and the memory-bridge module that wraps `pmem_read`/`pmem_write`. One transaction is outstanding at a time.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width; mask width is `DW/8`

- `clk` in 1: clock, all state updates on posedge
- `rst` in 1: synchronous reset, active-low (`rst==0` resets)
- `ifu_req_valid` in 1, `ifu_req_ready` out 1, `ifu_addr` in AW: fetch request
- `ifu_resp_valid` out 1, `ifu_rdata` out DW: fetch response
- `lsu_req_valid` in 1, `lsu_req_ready` out 1, `lsu_addr` in AW, `lsu_wen` in 1, `lsu_wdata` in DW, `lsu_wmask` in DW/8: data request
- `lsu_resp_valid` out 1, `lsu_rdata` out DW: data response / store ack
- `mem_req_valid` out 1, `mem_req_ready` in 1, `mem_addr` out AW, `mem_wen` out 1, `mem_wdata` out DW, `mem_wmask` out DW/8: downstream request
- `mem_resp_valid` in 1, `mem_rdata` in DW: downstream response (reads and write acks)

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE: `*_req_ready` is combinational and asserted only for the granted requester.
  - Grant rule: the only valid requester wins. If both are valid, the requester not granted last wins (round-robin).
  - `last_grant` resets to LSU, so the first tie goes to IFU.
- Handshake (`valid && ready`): latch addr, wen, wdata and wmask into request registers. IFU requests latch wen=0, wmask=0. Record the owner, update `last_grant`, then go to ISSUE.
- ISSUE: `mem_req_valid=1`, driven from the request registers, held stable until `mem_req_ready`. Then go to WAIT.
- WAIT: on `mem_resp_valid`, the next cycle pulses the owner's `*_resp_valid` for exactly 1 cycle.
  - Owner's `*_rdata` = captured `mem_rdata` for reads; 0 for stores.
  - FSM returns to IDLE in that same response cycle, so a new handshake can coincide with the response pulse.
- Addresses pass through unchanged. Word alignment is the requester's job.
- Responses have no backpressure. Requesters must accept the pulse.
- `*_rdata` holds its value until the next response to the same requester.
- `mem_resp_valid` in IDLE or ISSUE is ignored.
- `mem_req_ready` and `mem_resp_valid` may both arrive in ISSUE. In that case `mem_resp_valid` is ignored, and memory must respond no earlier than the cycle after acceptance.

## Timing
- Reset values:
  - state=IDLE, `last_grant`=LSU
  - all `*_resp_valid`=0, all `*_rdata`=0
  - `mem_req_valid`=0, `mem_addr`=0, `mem_wen`=0, `mem_wdata`=0, `mem_wmask`=0
- Reset is checked before all other logic. Asserting `rst=0` mid-transaction drops the transaction: no response pulse, FSM to IDLE.
- Best-case latency, with `mem_req_ready=1` and memory responding 1 cycle after acceptance:
  - handshake at cycle T
  - `mem_req_valid` at T+1
  - `mem_resp_valid` at T+2
  - `*_resp_valid` at T+3
- Back-to-back: a new handshake at T+3 gives a throughput of one transaction per 3 cycles minimum.
- `*_req_ready`=0 in ISSUE and WAIT, and 0 while in reset.

## Structure
- Shared package `ysyx_25070198_pkg`:
  - `mem_arb_state_t` enum (IDLE/ISSUE/WAIT)
  - `GRANT_IFU=1'b0`, `GRANT_LSU=1'b1`
- Sub-module `ysyx_25070198_rr2`:
  - 2-way round-robin picker: `req[1:0]` and `last` in, one-hot `gnt` out
  - combinational; `last_grant` register stays in the arbiter
- The top replaces the direct `pmem_read`/`pmem_write` calls with this arbiter plus the memory bridge.

## Test plan
- IFU only: `ifu_addr=0x80000000`; memory returns `0x00100093` 1 cycle after accept -> `ifu_resp_valid` pulses at T+3 with `ifu_rdata=0x00100093`; `lsu_resp_valid` stays 0.
- Tie after reset: both valid at T, LSU load `0x80001000` -> IFU granted first. LSU is granted at the next IDLE and responds with its own data. `last_grant` alternates across 4 further ties: IFU, LSU, IFU, LSU.
- Store: `lsu_wen=1`, `wdata=0xDEADBEEF`, `wmask=4'b0011` -> `mem_wen=1`, `mem_wdata=0xDEADBEEF`, `mem_wmask=0011` presented in ISSUE. The ack produces an `lsu_resp_valid` pulse with `lsu_rdata=0`.
- Backpressure: `mem_req_ready` low for 5 cycles -> `mem_req_valid` and all `mem_*` fields stay stable for those cycles. Both `*_req_ready` stay 0 until the response.
- Reset mid-WAIT: `rst=0` for 1 cycle, then memory sends `mem_resp_valid` -> no `*_resp_valid` pulse, all outputs at reset values, and the next IFU request completes normally.
- Stray response: `mem_resp_valid=1` while in IDLE -> no response pulse, state unchanged.

Source files
------------

// File: rtl/ysyx_25070198_pkg.sv
// Shared types and constants for the ysyx_25070198 memory-side blocks.
package ysyx_25070198_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } mem_arb_state_t;

   localparam logic GRANT_IFU = 1'b0;
   localparam logic GRANT_LSU = 1'b1;

endpackage

// File: rtl/ysyx_25070198_rr2.sv
// Two-way round-robin picker. Bit 0 is IFU, bit 1 is LSU.
module ysyx_25070198_rr2
   import ysyx_25070198_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         // On a tie, favour whichever side was not served last.
         2'b11:   gnt = (last == GRANT_LSU) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/ysyx_25070198_mem_arbiter.sv
// Serialises IFU and LSU requests onto the single memory-bridge port,
// one outstanding transaction at a time, with a one-cycle response pulse.
//
// state | meaning
// IDLE  | ready offered to the round-robin winner, waiting for a handshake
// ISSUE | mem_req_valid held from the request registers until mem_req_ready
// WAIT  | request accepted, waiting for mem_resp_valid
module ysyx_25070198_mem_arbiter
   import ysyx_25070198_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [AW-1:0]     ifu_addr,
   output logic              ifu_resp_valid,
   output logic [DW-1:0]     ifu_rdata,

   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic [AW-1:0]     lsu_addr,
   input  logic              lsu_wen,
   input  logic [DW-1:0]     lsu_wdata,
   input  logic [DW/8-1:0]   lsu_wmask,
   output logic              lsu_resp_valid,
   output logic [DW-1:0]     lsu_rdata,

   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [AW-1:0]     mem_addr,
   output logic              mem_wen,
   output logic [DW-1:0]     mem_wdata,
   output logic [DW/8-1:0]   mem_wmask,
   input  logic              mem_resp_valid,
   input  logic [DW-1:0]     mem_rdata
);

   mem_arb_state_t   r_state;
   logic             r_last_grant;
   logic             r_owner;
   logic [AW-1:0]    r_addr;
   logic             r_wen;
   logic [DW-1:0]    r_wdata;
   logic [DW/8-1:0]  r_wmask;
   logic             r_mem_req_valid;
   logic             r_ifu_resp_valid;
   logic             r_lsu_resp_valid;
   logic [DW-1:0]    r_ifu_rdata;
   logic [DW-1:0]    r_lsu_rdata;

   logic [1:0]       w_gnt;
   logic             w_idle;
   logic             w_hs_ifu;
   logic             w_hs_lsu;

   ysyx_25070198_rr2 u_rr2 (
      .req  ({lsu_req_valid, ifu_req_valid}),
      .last (r_last_grant),
      .gnt  (w_gnt)
   );

   // Ready is gated by rst so nothing handshakes while reset is held.
   assign w_idle        = (r_state == IDLE) && rst;
   assign ifu_req_ready = w_idle && w_gnt[0];
   assign lsu_req_ready = w_idle && w_gnt[1];
   assign w_hs_ifu      = ifu_req_valid && ifu_req_ready;
   assign w_hs_lsu      = lsu_req_valid && lsu_req_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state          <= IDLE;
         r_last_grant     <= GRANT_LSU;
         r_owner          <= GRANT_IFU;
         r_addr           <= '0;
         r_wen            <= 1'b0;
         r_wdata          <= '0;
         r_wmask          <= '0;
         r_mem_req_valid  <= 1'b0;
         r_ifu_resp_valid <= 1'b0;
         r_lsu_resp_valid <= 1'b0;
         r_ifu_rdata      <= '0;
         r_lsu_rdata      <= '0;
      end else begin
         r_ifu_resp_valid <= 1'b0;
         r_lsu_resp_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_hs_lsu) begin
                  r_addr          <= lsu_addr;
                  r_wen           <= lsu_wen;
                  r_wdata         <= lsu_wdata;
                  r_wmask         <= lsu_wmask;
                  r_owner         <= GRANT_LSU;
                  r_last_grant    <= GRANT_LSU;
                  r_mem_req_valid <= 1'b1;
                  r_state         <= ISSUE;
               end else if (w_hs_ifu) begin
                  r_addr          <= ifu_addr;
                  r_wen           <= 1'b0;
                  r_wdata         <= '0;
                  r_wmask         <= '0;
                  r_owner         <= GRANT_IFU;
                  r_last_grant    <= GRANT_IFU;
                  r_mem_req_valid <= 1'b1;
                  r_state         <= ISSUE;
               end
            end
            ISSUE: begin
               if (mem_req_ready) begin
                  r_mem_req_valid <= 1'b0;
                  r_state         <= WAIT;
               end
            end
            WAIT: begin
               // Back to IDLE together with the pulse so the next handshake can overlap it.
               if (mem_resp_valid) begin
                  r_state <= IDLE;
                  if (r_owner == GRANT_IFU) begin
                     r_ifu_resp_valid <= 1'b1;
                     r_ifu_rdata      <= mem_rdata;
                  end else begin
                     r_lsu_resp_valid <= 1'b1;
                     r_lsu_rdata      <= r_wen ? '0 : mem_rdata;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_req_valid  = r_mem_req_valid;
   assign mem_addr       = r_addr;
   assign mem_wen        = r_wen;
   assign mem_wdata      = r_wdata;
   assign mem_wmask      = r_wmask;
   assign ifu_resp_valid = r_ifu_resp_valid;
   assign ifu_rdata      = r_ifu_rdata;
   assign lsu_resp_valid = r_lsu_resp_valid;
   assign lsu_rdata      = r_lsu_rdata;

endmodule

// File: tb/tb_ysyx_25070198_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter: request/response scoreboards
// fed by a table of transactions plus directed latency, stall, reset and stray-response cases.
module tb_ysyx_25070198_mem_arbiter;

   localparam logic OWN_IFU = 1'b0;
   localparam logic OWN_LSU = 1'b1;

   logic        clk, rst;
   logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
   logic [31:0] ifu_addr, ifu_rdata;
   logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [3:0]  lsu_wmask;
   logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wmask;

   ysyx_25070198_mem_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
      .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
      .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
      .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } req_t;

   typedef struct {
      logic        owner;
      logic [31:0] data;
   } rsp_t;

   typedef struct {
      logic        ifu_v;
      logic        lsu_v;
      logic [31:0] ia;
      logic [31:0] la;
      logic        wen;
      logic [31:0] wd;
      logic [3:0]  wm;
      logic        exp_first;
   } vec_t;

   req_t req_q[$];
   rsp_t rsp_q[$];

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   hs_cyc = 0;
   int   resp_cyc = 0;
   int   pulses = 0;
   int   acc_cnt = 0;
   logic tb_last = OWN_LSU;
   logic first_seen = 1'b0;
   logic first_owner = OWN_IFU;
   logic [31:0] last_ifu = '0;
   logic [31:0] last_lsu = '0;
   logic auto_mem = 1'b1;
   logic pend = 1'b0;
   int   pend_cnt = 0;
   int   resp_delay = 0;
   logic [31:0] pend_data = '0;

   function automatic logic [31:0] mdl(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0010_0093;
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic chk(input logic ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      logic hs_i, hs_l, acc, own, exp_w;
      req_t q;
      rsp_t r;
      #1;
      hs_i = ifu_req_valid && ifu_req_ready;
      hs_l = lsu_req_valid && lsu_req_ready;
      acc  = mem_req_valid && mem_req_ready;
      chk(!(ifu_req_ready && lsu_req_ready), "ready_excl", {ifu_req_ready, lsu_req_ready}, 0);
      if (hs_i || hs_l) begin
         own = hs_l ? OWN_LSU : OWN_IFU;
         if (ifu_req_valid && lsu_req_valid) begin
            exp_w = (tb_last == OWN_LSU) ? OWN_IFU : OWN_LSU;
            chk(own == exp_w, "tie_grant", own, exp_w);
         end
         if (!first_seen) begin
            first_seen  = 1'b1;
            first_owner = own;
         end
         tb_last = own;
         hs_cyc  = cyc;
         if (own == OWN_LSU) begin
            q = '{lsu_addr, lsu_wen, lsu_wdata, lsu_wmask};
            r = '{OWN_LSU, lsu_wen ? 32'h0 : mdl(lsu_addr)};
         end else begin
            q = '{ifu_addr, 1'b0, 32'h0, 4'h0};
            r = '{OWN_IFU, mdl(ifu_addr)};
         end
         req_q.push_back(q);
         rsp_q.push_back(r);
      end
      if (acc) begin
         acc_cnt++;
         if (req_q.size() == 0) chk(1'b0, "unexpected_mem_req", mem_addr, 0);
         else begin
            q = req_q.pop_front();
            chk(mem_addr == q.addr, "mem_addr", mem_addr, q.addr);
            chk(mem_wen == q.wen, "mem_wen", mem_wen, q.wen);
            chk(mem_wmask == q.wmask, "mem_wmask", mem_wmask, q.wmask);
            if (q.wen) chk(mem_wdata == q.wdata, "mem_wdata", mem_wdata, q.wdata);
         end
         pend = 1'b1;
         pend_cnt = resp_delay;
         pend_data = mdl(mem_addr);
      end
      @(posedge clk);
      #1;
      if (hs_i) ifu_req_valid = 1'b0;
      if (hs_l) lsu_req_valid = 1'b0;
      if (auto_mem) begin
         mem_resp_valid = 1'b0;
         mem_rdata = 32'h5555_AAAA;
         if (pend) begin
            if (pend_cnt == 0) begin
               mem_resp_valid = 1'b1;
               mem_rdata = pend_data;
               pend = 1'b0;
            end else pend_cnt--;
         end
      end
      if (ifu_resp_valid || lsu_resp_valid) begin
         pulses++;
         resp_cyc = cyc + 1;
         chk(!(ifu_resp_valid && lsu_resp_valid), "resp_excl", {ifu_resp_valid, lsu_resp_valid}, 0);
         if (rsp_q.size() == 0) chk(1'b0, "unexpected_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
         else begin
            r = rsp_q.pop_front();
            chk(lsu_resp_valid == r.owner, "resp_owner", lsu_resp_valid, r.owner);
            if (r.owner == OWN_LSU) begin
               chk(lsu_rdata == r.data, "lsu_rdata", lsu_rdata, r.data);
               last_lsu = r.data;
            end else begin
               chk(ifu_rdata == r.data, "ifu_rdata", ifu_rdata, r.data);
               last_ifu = r.data;
            end
         end
      end
      cyc++;
   endtask

   task automatic wait_drain(input int max);
      for (int i = 0; i < max; i++) begin
         if (rsp_q.size() == 0 && !ifu_req_valid && !lsu_req_valid) return;
         tick();
      end
      chk(1'b0, "drain_timeout", rsp_q.size(), 0);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk(!ifu_resp_valid && !lsu_resp_valid, {tag, "_resp_valid"}, {ifu_resp_valid, lsu_resp_valid}, 0);
      chk(ifu_rdata == 0, {tag, "_ifu_rdata"}, ifu_rdata, 0);
      chk(lsu_rdata == 0, {tag, "_lsu_rdata"}, lsu_rdata, 0);
      chk(!mem_req_valid && !mem_wen, {tag, "_mem_valid_wen"}, {mem_req_valid, mem_wen}, 0);
      chk(mem_addr == 0 && mem_wdata == 0 && mem_wmask == 0, {tag, "_mem_fields"}, mem_addr | mem_wdata | 32'(mem_wmask), 0);
      chk(!ifu_req_ready && !lsu_req_ready, {tag, "_req_ready"}, {ifu_req_ready, lsu_req_ready}, 0);
   endtask

   vec_t vecs[7];
   int   pc;

   initial begin
      rst = 1'b0;
      ifu_req_valid = 0; ifu_addr = 0;
      lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
      mem_req_ready = 1'b1; mem_resp_valid = 0; mem_rdata = 0;

      vecs[0] = '{1, 1, 32'h8000_0000, 32'h8000_1000, 0, 32'h0,         4'h0,    OWN_IFU};
      vecs[1] = '{1, 0, 32'h8000_0004, 32'h0,         0, 32'h0,         4'h0,    OWN_IFU};
      vecs[2] = '{1, 1, 32'h8000_0008, 32'h8000_1004, 0, 32'h0,         4'h0,    OWN_LSU};
      vecs[3] = '{0, 1, 32'h0,         32'h8000_2000, 1, 32'hDEAD_BEEF, 4'b0011, OWN_LSU};
      vecs[4] = '{1, 1, 32'h8000_000C, 32'h8000_1008, 0, 32'h0,         4'h0,    OWN_IFU};
      vecs[5] = '{1, 0, 32'h8000_0010, 32'h0,         0, 32'h0,         4'h0,    OWN_IFU};
      vecs[6] = '{1, 1, 32'h8000_0014, 32'h8000_2004, 1, 32'h0BAD_CAFE, 4'b1111, OWN_LSU};

      tick();
      tick();
      chk_reset_outputs("reset");
      rst = 1'b1;
      tick();

      foreach (vecs[k]) begin
         ifu_addr  = vecs[k].ia;
         lsu_addr  = vecs[k].la;
         lsu_wen   = vecs[k].wen;
         lsu_wdata = vecs[k].wd;
         lsu_wmask = vecs[k].wm;
         first_seen = 1'b0;
         ifu_req_valid = vecs[k].ifu_v;
         lsu_req_valid = vecs[k].lsu_v;
         wait_drain(60);
         chk(first_seen && first_owner == vecs[k].exp_first, "first_grant", first_owner, vecs[k].exp_first);
         chk(ifu_rdata == last_ifu, "ifu_rdata_hold", ifu_rdata, last_ifu);
         chk(lsu_rdata == last_lsu, "lsu_rdata_hold", lsu_rdata, last_lsu);
      end

      // Best-case latency, IFU only.
      lsu_wen = 0;
      ifu_addr = 32'h8000_0000;
      ifu_req_valid = 1'b1;
      wait_drain(20);
      chk(resp_cyc - hs_cyc == 3, "latency", resp_cyc - hs_cyc, 3);
      chk(ifu_rdata == 32'h0010_0093, "ifu_fetch_data", ifu_rdata, 32'h0010_0093);

      // Downstream backpressure for 5 cycles on a store.
      mem_req_ready = 1'b0;
      lsu_addr = 32'h8000_3000; lsu_wen = 1; lsu_wdata = 32'h1234_5678; lsu_wmask = 4'b1100;
      lsu_req_valid = 1'b1;
      for (int i = 0; i < 5 && !mem_req_valid; i++) tick();
      ifu_addr = 32'h8000_0018;
      ifu_req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk(mem_req_valid, "stall_valid", mem_req_valid, 1);
         chk(mem_addr == 32'h8000_3000 && mem_wen, "stall_addr_wen", mem_addr, 32'h8000_3000);
         chk(mem_wdata == 32'h1234_5678 && mem_wmask == 4'b1100, "stall_data", mem_wdata, 32'h1234_5678);
         chk(!ifu_req_ready && !lsu_req_ready, "stall_ready", {ifu_req_ready, lsu_req_ready}, 0);
      end
      mem_req_ready = 1'b1;
      wait_drain(40);
      lsu_wen = 0;

      // Reset while waiting on memory drops the transaction.
      resp_delay = 5;
      pc = acc_cnt;
      ifu_addr = 32'h8000_001C;
      ifu_req_valid = 1'b1;
      for (int i = 0; i < 10 && acc_cnt == pc; i++) tick();
      chk(acc_cnt == pc + 1, "reset_setup_accept", acc_cnt, pc + 1);
      rsp_q.delete();
      req_q.delete();
      pend = 1'b0;
      auto_mem = 1'b0;
      mem_resp_valid = 1'b0;
      rst = 1'b0;
      lsu_addr = 32'h8000_1100;
      lsu_req_valid = 1'b1;
      tick();
      chk_reset_outputs("midwait_reset");
      lsu_req_valid = 1'b0;
      rst = 1'b1;
      tb_last = OWN_LSU;
      last_ifu = '0;
      last_lsu = '0;
      mem_resp_valid = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      pc = pulses;
      tick();
      mem_resp_valid = 1'b0;
      tick();
      tick();
      chk(pulses == pc, "no_pulse_after_reset", pulses, pc);
      chk(ifu_rdata == 0 && lsu_rdata == 0, "rdata_after_reset", ifu_rdata | lsu_rdata, 0);
      auto_mem = 1'b1;
      resp_delay = 0;
      ifu_addr = 32'h8000_0000;
      ifu_req_valid = 1'b1;
      wait_drain(20);
      chk(ifu_rdata == 32'h0010_0093, "post_reset_ifu", ifu_rdata, 32'h0010_0093);

      // Stray response in IDLE must be ignored.
      auto_mem = 1'b0;
      mem_resp_valid = 1'b1;
      mem_rdata = 32'h0BAD_F00D;
      pc = pulses;
      tick();
      mem_resp_valid = 1'b0;
      tick();
      chk(pulses == pc, "stray_no_pulse", pulses, pc);
      chk(ifu_rdata == last_ifu, "stray_rdata_hold", ifu_rdata, last_ifu);
      ifu_addr = 32'h8000_0020;
      ifu_req_valid = 1'b1;
      #1;
      chk(ifu_req_ready, "stray_still_idle", ifu_req_ready, 1);
      auto_mem = 1'b1;
      wait_drain(20);
      chk(req_q.size() == 0, "req_queue_empty", req_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
